count_sequence_monitor: RTL and testbench

COUNT_SEQUENCE_MONITOR -- requirements
Module: count_sequence_monitor

---
 rtl/count_sequence_monitor.sv | 87 ++++++++
 tb/tb_count_sequence_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor: tracks an upstream 2-bit counter stream, locks onto it, counts wraps and mismatches, alarms on persistent errors
module count_sequence_monitor #(
   parameter int WRAP_W    = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        count_in,
   input  logic              sample_en,
   input  logic              clear,
   output logic              locked,
   output logic              alarm,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              seq_err,
   output logic [3:0]        err_count
);
   typedef enum logic [1:0] {HUNT, LOCKED, ALARM} state_t;
   state_t     state;
   logic [1:0] prev;
   logic       prev_valid;
   logic [3:0] miss;
   logic       step_ok;
   logic       is_wrap;
   logic [3:0] miss_next;
   // classify the current sample against the previously sampled value
   always_comb begin
      step_ok   = prev_valid && (count_in == prev + 2'd1);
      is_wrap   = (prev == 2'd3) && (count_in == 2'd0);
      miss_next = miss + 4'd1;
   end
   // lock/alarm FSM with registered flags, pulses and statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         prev       <= 2'd0;
         prev_valid <= 1'b0;
         miss       <= 4'd0;
         locked     <= 1'b0;
         alarm      <= 1'b0;
         wrap_pulse <= 1'b0;
         wrap_count <= '0;
         seq_err    <= 1'b0;
         err_count  <= 4'd0;
      end else begin
         wrap_pulse <= 1'b0;
         seq_err    <= 1'b0;
         if (clear) begin
            state      <= HUNT;
            locked     <= 1'b0;
            alarm      <= 1'b0;
            wrap_count <= '0;
            err_count  <= 4'd0;
            miss       <= 4'd0;
            prev_valid <= sample_en;
            if (sample_en) prev <= count_in;
         end else if (sample_en) begin
            prev       <= count_in;
            prev_valid <= 1'b1;
            case (state)
               HUNT: if (step_ok) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  miss   <= 4'd0;
               end
               LOCKED: if (step_ok) begin
                  miss <= 4'd0;
                  if (is_wrap) begin
                     wrap_pulse <= 1'b1;
                     wrap_count <= wrap_count + WRAP_W'(1);
                  end
               end else begin
                  seq_err   <= 1'b1;
                  err_count <= err_count + {3'd0, err_count != 4'hf};
                  miss      <= miss_next;
                  if (miss_next == 4'(ERR_LIMIT)) begin
                     state  <= ALARM;
                     locked <= 1'b0;
                     alarm  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_count_sequence_monitor.sv
// tb_count_sequence_monitor: randomized and directed checks of two monitor instances (ERR_LIMIT 3 and 15) against a behavioural model
module tb_count_sequence_monitor;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_en = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] count_in = 2'd0;
   logic       locked_a, alarm_a, wp_a, se_a, locked_b, alarm_b, wp_b, se_b;
   logic [7:0] wc_a, wc_b;
   logic [3:0] ec_a, ec_b;
   int errors = 0;
   int checks = 0;
   int m_prev[2], m_pv[2], m_mode[2], m_miss[2], m_wraps[2], m_errs[2], m_wp[2], m_se[2];
   int lim[2] = '{3, 15};

   always #5 clk = ~clk;

   count_sequence_monitor #(.WRAP_W(8), .ERR_LIMIT(3)) dut_a (
      .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
      .locked(locked_a), .alarm(alarm_a), .wrap_pulse(wp_a), .wrap_count(wc_a),
      .seq_err(se_a), .err_count(ec_a));

   count_sequence_monitor #(.WRAP_W(8), .ERR_LIMIT(15)) dut_b (
      .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
      .locked(locked_b), .alarm(alarm_b), .wrap_pulse(wp_b), .wrap_count(wc_b),
      .seq_err(se_b), .err_count(ec_b));

   wire [15:0] obs_a = {locked_a, alarm_a, wp_a, wc_a, se_a, ec_a};
   wire [15:0] obs_b = {locked_b, alarm_b, wp_b, wc_b, se_b, ec_b};

   // mode: 0 hunting, 1 locked, 2 alarmed
   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_prev[k] = 0; m_pv[k] = 0; m_mode[k] = 0; m_miss[k] = 0;
         m_wraps[k] = 0; m_errs[k] = 0; m_wp[k] = 0; m_se[k] = 0;
      end
   endfunction

   function automatic void model_edge(bit en, int cin, bit clr);
      for (int k = 0; k < 2; k++) begin
         m_wp[k] = 0;
         m_se[k] = 0;
         if (clr) begin
            m_mode[k] = 0; m_wraps[k] = 0; m_errs[k] = 0; m_miss[k] = 0;
            m_pv[k] = en;
            if (en) m_prev[k] = cin;
         end else if (en) begin
            bit ok;
            ok = m_pv[k] != 0 && cin == (m_prev[k] + 1) % 4;
            if (m_mode[k] == 0 && ok) begin
               m_mode[k] = 1;
               m_miss[k] = 0;
            end else if (m_mode[k] == 1 && ok) begin
               m_miss[k] = 0;
               if (m_prev[k] == 3 && cin == 0) begin
                  m_wp[k] = 1;
                  m_wraps[k] = (m_wraps[k] + 1) % 256;
               end
            end else if (m_mode[k] == 1) begin
               m_se[k] = 1;
               m_errs[k] = m_errs[k] < 15 ? m_errs[k] + 1 : 15;
               m_miss[k]++;
               if (m_miss[k] == lim[k]) m_mode[k] = 2;
            end
            m_prev[k] = cin;
            m_pv[k] = 1;
         end
      end
   endfunction

   function automatic logic [15:0] pack(int k);
      logic [7:0] w;
      logic [3:0] e;
      w = m_wraps[k][7:0];
      e = m_errs[k][3:0];
      return {m_mode[k] == 1, m_mode[k] == 2, m_wp[k] != 0, w, m_se[k] != 0, e};
   endfunction

   task automatic step(input bit en, input int cin, input bit clr);
      @(negedge clk);
      sample_en = en;
      count_in  = cin[1:0];
      clear     = clr;
      @(posedge clk);
      model_edge(en, cin, clr);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({obs_a, obs_b} !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got %h want 0", {obs_a, obs_b});
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 5; i++) begin
         step(1, i % 4, 0);
         checks++;
         if ({obs_a, obs_b} !== {pack(0), pack(1)}) begin
            errors++;
            $display("FAIL basic_step%0d got %h want %h", i, {obs_a, obs_b}, {pack(0), pack(1)});
         end
         if (i == 1) begin
            checks++;
            if (locked_a !== 1'b1) begin
               errors++;
               $display("FAIL basic_lock got %b want 1", locked_a);
            end
         end
      end
      checks++;
      if ({wp_a, wc_a, se_a} !== {1'b1, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL basic_wrap got wp=%b wc=%0d se=%b want wp=1 wc=1 se=0", wp_a, wc_a, se_a);
      end
   endtask

   task automatic test_free_run();
      for (int i = 1; i <= 40; i++) begin
         step(1, i % 4, 0);
         checks++;
         if ({obs_a, obs_b} !== {pack(0), pack(1)} || locked_a !== 1'b1) begin
            errors++;
            $display("FAIL free_run_%0d got %h want %h", i, {obs_a, obs_b}, {pack(0), pack(1)});
         end
      end
      checks++;
      if ({wc_a, ec_a} !== {8'd11, 4'd0}) begin
         errors++;
         $display("FAIL free_run_totals got wc=%0d ec=%0d want wc=11 ec=0", wc_a, ec_a);
      end
   endtask

   task automatic test_glitch();
      int seq[4] = '{1, 3, 1, 2};
      for (int i = 0; i < 4; i++) begin
         step(1, seq[i], 0);
         checks++;
         if ({obs_a, obs_b} !== {pack(0), pack(1)}) begin
            errors++;
            $display("FAIL glitch_%0d got %h want %h", i, {obs_a, obs_b}, {pack(0), pack(1)});
         end
      end
      checks++;
      if ({ec_a, locked_a, alarm_a} !== {4'd2, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL glitch_totals got ec=%0d lk=%b al=%b want ec=2 lk=1 al=0", ec_a, locked_a, alarm_a);
      end
   endtask

   task automatic test_stuck_alarm();
      int seq[7] = '{2, 2, 2, 3, 0, 1, 2};
      for (int i = 0; i < 7; i++) begin
         step(1, seq[i], 0);
         checks++;
         if ({obs_a, obs_b} !== {pack(0), pack(1)}) begin
            errors++;
            $display("FAIL stuck_%0d got %h want %h", i, {obs_a, obs_b}, {pack(0), pack(1)});
         end
      end
      checks++;
      if ({alarm_a, locked_a, ec_a, wc_a} !== {1'b1, 1'b0, 4'd5, 8'd11}) begin
         errors++;
         $display("FAIL stuck_alarm got al=%b lk=%b ec=%0d wc=%0d want al=1 lk=0 ec=5 wc=11", alarm_a, locked_a, ec_a, wc_a);
      end
      step(0, 0, 1);
      checks++;
      if ({obs_a, obs_b} !== 32'h0) begin
         errors++;
         $display("FAIL stuck_clear got %h want 0", {obs_a, obs_b});
      end
   endtask

   task automatic test_saturate();
      int v;
      step(1, 0, 0);
      step(1, 1, 0);
      v = 1;
      for (int r = 0; r < 5; r++) begin
         for (int h = 0; h < 5; h++) begin
            if (h == 4) v = (v + 1) % 4;
            step(1, v, 0);
            checks++;
            if ({obs_a, obs_b} !== {pack(0), pack(1)}) begin
               errors++;
               $display("FAIL saturate_%0d_%0d got %h want %h", r, h, {obs_a, obs_b}, {pack(0), pack(1)});
            end
         end
      end
      checks++;
      if ({ec_b, locked_b, alarm_a} !== {4'd15, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL saturate_totals got ec=%0d lk=%b al_a=%b want ec=15 lk=1 al_a=1", ec_b, locked_b, alarm_a);
      end
   endtask

   task automatic test_random();
      int last = 0;
      for (int i = 0; i < 400; i++) begin
         bit en, clr;
         int cin;
         en  = $urandom_range(0, 3) != 0;
         clr = $urandom_range(0, 39) == 0;
         cin = $urandom_range(0, 9) < 7 ? (last + 1) % 4 : int'($urandom_range(0, 3));
         if (en) last = cin;
         step(en, cin, clr);
         checks++;
         if ({obs_a, obs_b} !== {pack(0), pack(1)} || (locked_a && alarm_a) || (locked_b && alarm_b)) begin
            errors++;
            $display("FAIL random_%0d got %h want %h", i, {obs_a, obs_b}, {pack(0), pack(1)});
         end
      end
   endtask

   task automatic test_async_rst();
      step(0, 0, 1);
      step(1, 0, 0);
      for (int i = 1; i <= 20; i++) step(1, i % 4, 0);
      checks++;
      if ({wc_a, locked_a} !== {8'd5, 1'b1}) begin
         errors++;
         $display("FAIL pre_rst got wc=%0d lk=%b want wc=5 lk=1", wc_a, locked_a);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({obs_a, obs_b} !== 32'h0) begin
         errors++;
         $display("FAIL async_rst got %h want 0", {obs_a, obs_b});
      end
      @(negedge clk);
      rst = 1'b0;
      step(1, 2, 0);
      step(1, 3, 0);
      step(1, 1, 1);
      checks++;
      if ({obs_a, obs_b} !== 32'h0) begin
         errors++;
         $display("FAIL clear_wins got %h want 0", {obs_a, obs_b});
      end
      step(1, 2, 0);
      checks++;
      if ({obs_a, obs_b} !== {pack(0), pack(1)} || locked_a !== 1'b1) begin
         errors++;
         $display("FAIL clear_loads_prev got %h want %h", {obs_a, obs_b}, {pack(0), pack(1)});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_free_run();
      test_glitch();
      test_stuck_alarm();
      test_saturate();
      test_random();
      test_async_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
